// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: host-side bus master for an 8259 PIC.
// Writes the ICW1..ICW4 + OCW1 init list on start, then serves EOI and mask
// writes and runs two-pulse INTA cycles to fetch interrupt vectors.
// Optional build macro PIC_STATUS_READ_EN adds an OCW3 + IRR/ISR status read.

module pic_host_sequencer #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] cfg_icw1,
    input  logic [7:0] cfg_icw2,
    input  logic [7:0] cfg_icw3,
    input  logic [7:0] cfg_icw4,
    input  logic [7:0] cfg_mask,
    input  logic       eoi_req,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    input  logic       interrupt_to_cpu,
    input  logic [7:0] data_in,
`ifdef PIC_STATUS_READ_EN
    input  logic       status_req,
    input  logic       status_sel,
    output logic [7:0] status_data,
    output logic       status_valid,
`endif
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       interrupt_acknowledge_n,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] vector,
    output logic       vector_valid
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_WR_SETUP   = 4'd1;
    localparam logic [3:0] ST_WR_STROBE  = 4'd2;
    localparam logic [3:0] ST_WR_HOLD    = 4'd3;
    localparam logic [3:0] ST_GAP        = 4'd4;
    localparam logic [3:0] ST_RUN_IDLE   = 4'd5;
    localparam logic [3:0] ST_INTA1      = 4'd6;
    localparam logic [3:0] ST_INTA_GAP   = 4'd7;
    localparam logic [3:0] ST_INTA2      = 4'd8;
    localparam logic [3:0] ST_INTA_FLUSH = 4'd9;
`ifdef PIC_STATUS_READ_EN
    localparam logic [3:0] ST_RD_SETUP   = 4'd10;
    localparam logic [3:0] ST_RD_STROBE  = 4'd11;
    localparam logic [3:0] ST_RD_HOLD    = 4'd12;
`endif

    // Terminal counts; the flush spans GAP_CYCLES + 2 so the 2-flop
    // synchronizer has drained before RUN_IDLE looks at it again.
    localparam logic [7:0] STB_LAST   = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] FLUSH_LAST = 8'(GAP_CYCLES + 1);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;           // init word index: 0 ICW1 .. 4 OCW1
    logic       in_init_q, in_init_d;
    logic [1:0] ic_flags_q, ic_flags_d; // captured cfg_icw1[1:0] (SNGL, IC4)
    logic [7:0] icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic [7:0] cfg_mask_q, cfg_mask_d;
    logic       init_done_q, init_done_d;
    logic       eoi_pend_q, eoi_pend_d;
    logic       mask_pend_q, mask_pend_d;
    logic [7:0] mask_data_q, mask_data_d;
    logic [7:0] wdata_q, wdata_d;
    logic       a0_q, a0_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_valid_q, vector_valid_d;
    logic       sync1_q, sync2_q;
`ifdef PIC_STATUS_READ_EN
    logic       status_pend_q, status_pend_d;
    logic       status_sel_q, status_sel_d;
    logic       rd_next_q, rd_next_d;
    logic [7:0] status_data_q, status_data_d;
    logic       status_valid_q, status_valid_d;
`endif

    logic       start_ok;
    logic [2:0] nidx;
    logic [7:0] nword;

    // Two-flop synchronizer for the asynchronous PIC INT pin
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= interrupt_to_cpu;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: init word list, bus cycle sequencing, request capture
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        in_init_d      = in_init_q;
        ic_flags_d     = ic_flags_q;
        icw2_d         = icw2_q;
        icw3_d         = icw3_q;
        icw4_d         = icw4_q;
        cfg_mask_d     = cfg_mask_q;
        init_done_d    = init_done_q;
        eoi_pend_d     = eoi_pend_q;
        mask_pend_d    = mask_pend_q;
        mask_data_d    = mask_data_q;
        wdata_d        = wdata_q;
        a0_d           = a0_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
`ifdef PIC_STATUS_READ_EN
        status_pend_d  = status_pend_q;
        status_sel_d   = status_sel_q;
        rd_next_d      = rd_next_q;
        status_data_d  = status_data_q;
        status_valid_d = 1'b0;
`endif
        start_ok = start && (state_q == ST_IDLE || state_q == ST_RUN_IDLE);

        // Next init word, skipping ICW3 in single mode and ICW4 without IC4
        nidx = idx_q + 3'd1;
        if (nidx == 3'd2 && ic_flags_q[1])  nidx = 3'd3;
        if (nidx == 3'd3 && !ic_flags_q[0]) nidx = 3'd4;
        case (nidx)
            3'd1:    nword = icw2_q;
            3'd2:    nword = icw3_q;
            3'd3:    nword = icw4_q;
            default: nword = cfg_mask_q;
        endcase

        if (start_ok) begin
            ic_flags_d  = cfg_icw1[1:0];
            icw2_d      = cfg_icw2;
            icw3_d      = cfg_icw3;
            icw4_d      = cfg_icw4;
            cfg_mask_d  = cfg_mask;
            init_done_d = 1'b0;
            in_init_d   = 1'b1;
            idx_d       = 3'd0;
            eoi_pend_d  = 1'b0;
            mask_pend_d = 1'b0;
`ifdef PIC_STATUS_READ_EN
            status_pend_d = 1'b0;
            rd_next_d     = 1'b0;
`endif
            wdata_d     = cfg_icw1 | 8'h10;
            a0_d        = 1'b0;
            state_d     = ST_WR_SETUP;
        end else begin
            case (state_q)
                ST_RUN_IDLE: begin
                    if (eoi_pend_q) begin
                        eoi_pend_d = 1'b0;
                        wdata_d    = 8'h20;
                        a0_d       = 1'b0;
                        state_d    = ST_WR_SETUP;
                    end else if (mask_pend_q) begin
                        mask_pend_d = 1'b0;
                        wdata_d     = mask_data_q;
                        a0_d        = 1'b1;
                        state_d     = ST_WR_SETUP;
`ifdef PIC_STATUS_READ_EN
                    end else if (status_pend_q) begin
                        status_pend_d = 1'b0;
                        rd_next_d     = 1'b1;
                        wdata_d       = {7'b0000101, status_sel_q};
                        a0_d          = 1'b0;
                        state_d       = ST_WR_SETUP;
`endif
                    end else if (sync2_q) begin
                        cnt_d   = 8'd0;
                        state_d = ST_INTA1;
                    end
                end
                ST_WR_SETUP: begin
                    cnt_d   = 8'd0;
                    state_d = ST_WR_STROBE;
                end
                ST_WR_STROBE: begin
                    if (cnt_q == STB_LAST) state_d = ST_WR_HOLD;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
                ST_WR_HOLD: begin
                    cnt_d   = 8'd0;
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (cnt_q != GAP_LAST) begin
                        cnt_d = cnt_q + 8'd1;
                    end else if (in_init_q && idx_q != 3'd4) begin
                        idx_d   = nidx;
                        wdata_d = nword;
                        a0_d    = 1'b1;
                        state_d = ST_WR_SETUP;
                    end else if (in_init_q) begin
                        in_init_d   = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = ST_RUN_IDLE;
`ifdef PIC_STATUS_READ_EN
                    end else if (rd_next_q) begin
                        rd_next_d = 1'b0;
                        state_d   = ST_RD_SETUP;
`endif
                    end else begin
                        state_d = ST_RUN_IDLE;
                    end
                end
                ST_INTA1: begin
                    if (cnt_q == STB_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = ST_INTA_GAP;
                    end else cnt_d = cnt_q + 8'd1;
                end
                ST_INTA_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = ST_INTA2;
                    end else cnt_d = cnt_q + 8'd1;
                end
                ST_INTA2: begin
                    if (cnt_q == STB_LAST) begin
                        vector_d       = data_in;
                        vector_valid_d = 1'b1;
                        cnt_d          = 8'd0;
                        state_d        = ST_INTA_FLUSH;
                    end else cnt_d = cnt_q + 8'd1;
                end
                ST_INTA_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) state_d = ST_RUN_IDLE;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
`ifdef PIC_STATUS_READ_EN
                ST_RD_SETUP: begin
                    cnt_d   = 8'd0;
                    state_d = ST_RD_STROBE;
                end
                ST_RD_STROBE: begin
                    if (cnt_q == STB_LAST) begin
                        status_data_d  = data_in;
                        status_valid_d = 1'b1;
                        state_d        = ST_RD_HOLD;
                    end else cnt_d = cnt_q + 8'd1;
                end
                ST_RD_HOLD: begin
                    cnt_d   = 8'd0;
                    state_d = ST_GAP;
                end
`endif
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Sticky requests; a set overrides a same-cycle dispatch clear
        if (init_done_q && !start_ok) begin
            if (eoi_req) eoi_pend_d = 1'b1;
            if (mask_wr) begin
                mask_pend_d = 1'b1;
                mask_data_d = mask_data;
            end
`ifdef PIC_STATUS_READ_EN
            if (status_req) begin
                status_pend_d = 1'b1;
                status_sel_d  = status_sel;
            end
`endif
        end
    end

    // State and datapath registers; reset forces bus-idle values at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            idx_q          <= 3'd0;
            in_init_q      <= 1'b0;
            ic_flags_q     <= 2'd0;
            icw2_q         <= 8'd0;
            icw3_q         <= 8'd0;
            icw4_q         <= 8'd0;
            cfg_mask_q     <= 8'd0;
            init_done_q    <= 1'b0;
            eoi_pend_q     <= 1'b0;
            mask_pend_q    <= 1'b0;
            mask_data_q    <= 8'd0;
            wdata_q        <= 8'd0;
            a0_q           <= 1'b0;
            vector_q       <= 8'd0;
            vector_valid_q <= 1'b0;
`ifdef PIC_STATUS_READ_EN
            status_pend_q  <= 1'b0;
            status_sel_q   <= 1'b0;
            rd_next_q      <= 1'b0;
            status_data_q  <= 8'd0;
            status_valid_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            in_init_q      <= in_init_d;
            ic_flags_q     <= ic_flags_d;
            icw2_q         <= icw2_d;
            icw3_q         <= icw3_d;
            icw4_q         <= icw4_d;
            cfg_mask_q     <= cfg_mask_d;
            init_done_q    <= init_done_d;
            eoi_pend_q     <= eoi_pend_d;
            mask_pend_q    <= mask_pend_d;
            mask_data_q    <= mask_data_d;
            wdata_q        <= wdata_d;
            a0_q           <= a0_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
`ifdef PIC_STATUS_READ_EN
            status_pend_q  <= status_pend_d;
            status_sel_q   <= status_sel_d;
            rd_next_q      <= rd_next_d;
            status_data_q  <= status_data_d;
            status_valid_q <= status_valid_d;
`endif
        end
    end

    // Bus pins are pure state decodes, so reset deasserts them immediately
    assign write_enable_n          = (state_q != ST_WR_STROBE);
    assign data_oe                 = (state_q == ST_WR_SETUP) || (state_q == ST_WR_STROBE) ||
                                     (state_q == ST_WR_HOLD);
    assign interrupt_acknowledge_n = !((state_q == ST_INTA1) || (state_q == ST_INTA2));
    assign busy                    = !((state_q == ST_IDLE) || (state_q == ST_RUN_IDLE));
`ifdef PIC_STATUS_READ_EN
    assign chip_select_n = !(data_oe || (state_q == ST_RD_SETUP) ||
                             (state_q == ST_RD_STROBE) || (state_q == ST_RD_HOLD));
    assign read_enable_n = (state_q != ST_RD_STROBE);
    assign status_data   = status_data_q;
    assign status_valid  = status_valid_q;
`else
    assign chip_select_n = !data_oe;
    assign read_enable_n = 1'b1;
`endif
    assign A0           = a0_q;
    assign data_out     = wdata_q;
    assign init_done    = init_done_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Testbench for pic_host_sequencer: a bus monitor logs every write and INTA
// pulse; a reference model builds the expected transaction list from the
// init/priority rules and the log is compared entry by entry.

module tb_pic_host_sequencer;

    localparam int SC = 2;
    localparam int GC = 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_icw1 = 8'h00, cfg_icw2 = 8'h00, cfg_icw3 = 8'h00, cfg_icw4 = 8'h00;
    logic [7:0] cfg_mask = 8'h00;
    logic       eoi_req = 1'b0, mask_wr = 1'b0;
    logic [7:0] mask_data = 8'h00;
    logic       interrupt_to_cpu = 1'b0;
    logic [7:0] data_in;
    logic       chip_select_n, read_enable_n, write_enable_n, A0, data_oe;
    logic       interrupt_acknowledge_n, busy, init_done, vector_valid;
    logic [7:0] data_out, vector;

    pic_host_sequencer #(.STROBE_CYCLES(SC), .GAP_CYCLES(GC)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .cfg_icw1(cfg_icw1), .cfg_icw2(cfg_icw2), .cfg_icw3(cfg_icw3), .cfg_icw4(cfg_icw4),
        .cfg_mask(cfg_mask), .eoi_req(eoi_req), .mask_wr(mask_wr), .mask_data(mask_data),
        .interrupt_to_cpu(interrupt_to_cpu), .data_in(data_in),
        .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
        .write_enable_n(write_enable_n), .A0(A0), .data_out(data_out), .data_oe(data_oe),
        .interrupt_acknowledge_n(interrupt_acknowledge_n), .busy(busy),
        .init_done(init_done), .vector(vector), .vector_valid(vector_valid)
    );

    always #5 clock = ~clock;

    // PIC model: vector only on the second (even) INTA pulse, junk on the first
    int         inta_falls = 0;
    logic [7:0] pic_vec = 8'h00;
    always @(negedge interrupt_acknowledge_n) inta_falls <= inta_falls + 1;
    assign data_in = (!interrupt_acknowledge_n && inta_falls[0] == 1'b0) ? pic_vec : 8'h5A;

    typedef struct { int kind; logic [7:0] data; logic a0; int low; int len; bit ok; } ev_t;
    typedef struct { int kind; logic [7:0] data; logic a0; int gap; } xp_t;
    ev_t log_q[$];
    xp_t exp_q[$];
    int  rd_idx = 0;
    int  vv_cycles = 0;
    bit  overlap = 1'b0;
    int  checks = 0;
    int  errors = 0;

    // Bus monitor: one event per chip-select window and per INTA pulse
    initial begin : monitor
        int cs_run, wr_run, oe_bad, inta_run, hi_run, gap_before;
        logic [7:0] cur_d;
        logic cur_a0;
        ev_t ev;
        cs_run = 0; wr_run = 0; oe_bad = 0; inta_run = 0; hi_run = 1000; gap_before = 0;
        cur_d = 8'h00; cur_a0 = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                cs_run = 0; wr_run = 0; oe_bad = 0; inta_run = 0; hi_run = 1000;
            end else begin
                if (!interrupt_acknowledge_n &&
                    (!chip_select_n || !write_enable_n || !read_enable_n || data_oe))
                    overlap = 1'b1;
                if (!chip_select_n) begin
                    cs_run++;
                    if (!write_enable_n) wr_run++;
                    if (!data_oe) oe_bad++;
                    cur_d = data_out; cur_a0 = A0;
                end else if (cs_run > 0) begin
                    ev.kind = 0; ev.data = cur_d; ev.a0 = cur_a0;
                    ev.low = wr_run; ev.len = cs_run; ev.ok = (oe_bad == 0);
                    log_q.push_back(ev);
                    cs_run = 0; wr_run = 0; oe_bad = 0;
                end
                if (!interrupt_acknowledge_n) begin
                    if (inta_run == 0) gap_before = hi_run;
                    inta_run++;
                end else begin
                    if (inta_run > 0) begin
                        ev.kind = 1; ev.data = 8'h00; ev.a0 = 1'b0;
                        ev.low = inta_run; ev.len = gap_before; ev.ok = 1'b1;
                        log_q.push_back(ev);
                        inta_run = 0; hi_run = 0;
                    end
                    hi_run++;
                end
                if (vector_valid) vv_cycles++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_w(input logic [7:0] d, input logic a0);
        xp_t x;
        x.kind = 0; x.data = d; x.a0 = a0; x.gap = -1;
        exp_q.push_back(x);
    endtask

    task automatic push_i(input int gap);
        xp_t x;
        x.kind = 1; x.data = 8'h00; x.a0 = 1'b0; x.gap = gap;
        exp_q.push_back(x);
    endtask

    // Compare the monitor log against the expected transactions, then clear
    task automatic check_log(input string tag);
        int avail;
        ev_t ev;
        avail = log_q.size() - rd_idx;
        chk({tag, " count"}, avail, exp_q.size());
        foreach (exp_q[i]) begin
            if (rd_idx < log_q.size()) begin
                ev = log_q[rd_idx];
                rd_idx++;
                $display("txn %s #%0d: %s data=%02h a0=%0d low=%0d len=%0d",
                         tag, i, ev.kind == 0 ? "WRITE" : "INTA ", ev.data, ev.a0, ev.low, ev.len);
                chk($sformatf("%s[%0d] kind", tag, i), ev.kind, exp_q[i].kind);
                chk($sformatf("%s[%0d] low", tag, i), ev.low, SC);
                if (exp_q[i].kind == 0) begin
                    chk($sformatf("%s[%0d] data", tag, i), ev.data, exp_q[i].data);
                    chk($sformatf("%s[%0d] a0", tag, i), ev.a0, exp_q[i].a0);
                    chk($sformatf("%s[%0d] cs_len", tag, i), ev.len, SC + 2);
                    chk($sformatf("%s[%0d] oe", tag, i), ev.ok, 1);
                end else if (exp_q[i].gap >= 0) begin
                    chk($sformatf("%s[%0d] gap", tag, i), ev.len, exp_q[i].gap);
                end
            end
        end
        rd_idx = log_q.size();
        exp_q.delete();
    endtask

    // Reference model of the init list plus a timed run; optionally re-pulses
    // start mid-sequence with new cfg values, which must change nothing
    task automatic run_init(input string tag, input logic [7:0] i1, input logic [7:0] i2,
                            input logic [7:0] i3, input logic [7:0] i4, input logic [7:0] m,
                            input bit busy_start);
        int n, words;
        push_w(i1 | 8'h10, 1'b0);
        push_w(i2, 1'b1);
        if (!i1[1]) push_w(i3, 1'b1);
        if (i1[0])  push_w(i4, 1'b1);
        push_w(m, 1'b1);
        words = exp_q.size();
        cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4; cfg_mask = m;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (busy_start) begin
            cfg_icw1 = 8'($urandom); cfg_icw2 = 8'($urandom); cfg_icw3 = 8'($urandom);
            cfg_icw4 = 8'($urandom); cfg_mask = 8'($urandom);
        end
        n = 0;
        while (!init_done && n < 300) begin
            @(negedge clock);
            n++;
            start = (busy_start && n == 3);
        end
        start = 1'b0;
        chk({tag, " init_latency"}, n, 5 * words);
        tick(3);
        check_log(tag);
    endtask

    // Interrupt with optional same-cycle EOI / mask requests
    task automatic run_irq(input string tag, input logic [7:0] vec, input bit eoi,
                           input bit msk, input logic [7:0] mval);
        int n, vv0;
        if (eoi) push_w(8'h20, 1'b0);
        if (msk) push_w(mval, 1'b1);
        push_i(-1);
        push_i(GC);
        vv0 = vv_cycles;
        pic_vec = vec; interrupt_to_cpu = 1'b1;
        eoi_req = eoi; mask_wr = msk; mask_data = mval;
        @(negedge clock);
        eoi_req = 1'b0; mask_wr = 1'b0; mask_data = 8'($urandom);
        if (!eoi && !msk) begin
            n = 1;
            while (interrupt_acknowledge_n && n < 10) begin
                @(negedge clock);
                n++;
            end
            chk({tag, " inta_latency_le3"}, (n <= 3), 1);
        end
        n = 0;
        while (!vector_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " vector_valid"}, vector_valid, 1);
        chk({tag, " vector"}, vector, vec);
        interrupt_to_cpu = 1'b0;
        tick(15);
        chk({tag, " vv_cycles"}, vv_cycles - vv0, 1);
        check_log(tag);
    endtask

    initial begin : stimulus
        int n;
        logic [7:0] r1;
        tick(3);
        chk("rst cs_n", chip_select_n, 1);
        chk("rst rd_n", read_enable_n, 1);
        chk("rst wr_n", write_enable_n, 1);
        chk("rst inta_n", interrupt_acknowledge_n, 1);
        chk("rst a0", A0, 0);
        chk("rst data_out", data_out, 0);
        chk("rst data_oe", data_oe, 0);
        chk("rst busy", busy, 0);
        chk("rst init_done", init_done, 0);
        chk("rst vector", vector, 0);
        chk("rst vector_valid", vector_valid, 0);
        reset_n = 1'b1;
        tick(2);

        // Requests before init must be dropped
        eoi_req = 1'b1; mask_wr = 1'b1; mask_data = 8'h33;
        @(negedge clock);
        eoi_req = 1'b0; mask_wr = 1'b0;
        tick(10);
        chk("preinit idle", log_q.size() - rd_idx, 0);
        chk("preinit busy", busy, 0);

        run_init("init_single", 8'h13, 8'h20, 8'($urandom), 8'h01, 8'hFB, 1'b0);
        tick(10);
        chk("post_init quiet", log_q.size() - rd_idx, 0);
        run_init("init_cascade", 8'h10, 8'($urandom), 8'h04, 8'($urandom), 8'($urandom), 1'b0);
        run_irq("irq_21", 8'h21, 1'b0, 1'b0, 8'h00);
        run_irq("eoi_mask_irq", 8'($urandom), 1'b1, 1'b1, 8'h7F);
        run_init("start_busy", 8'h11, 8'h48, 8'h02, 8'h0F, 8'hA5, 1'b1);

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0)
                run_init($sformatf("rnd_init%0d", i), 8'($urandom), 8'($urandom),
                         8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            else
                run_irq($sformatf("rnd_irq%0d", i), 8'($urandom), 1'($urandom),
                        1'($urandom), 8'($urandom));
        end

        // Asynchronous reset in the middle of a mask write strobe
        r1 = 8'($urandom);
        mask_wr = 1'b1; mask_data = r1 | 8'h01;
        @(negedge clock);
        mask_wr = 1'b0;
        n = 0;
        while (write_enable_n && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("rst_mid wr_low_seen", write_enable_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid wr_n", write_enable_n, 1);
        chk("rst_mid cs_n", chip_select_n, 1);
        chk("rst_mid data_oe", data_oe, 0);
        chk("rst_mid init_done", init_done, 0);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid a0", A0, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick(10);
        eoi_req = 1'b1;
        @(negedge clock);
        eoi_req = 1'b0;
        tick(10);
        chk("after_rst busy", busy, 0);
        chk("after_rst init_done", init_done, 0);
        chk("after_rst cs_n", chip_select_n, 1);
        chk("after_rst quiet", log_q.size() - rd_idx, 0);

        run_init("reinit", 8'h13, 8'h08, 8'h00, 8'h01, 8'hFE, 1'b0);
        run_irq("irq_after_rst", 8'($urandom), 1'b1, 1'b0, 8'h00);
        chk("inta_exclusive", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_host_sequencer.md
Name: pic_host_sequencer

Overview:
- Host-side controller that drives the 8259 PIC CPU-bus pins: chip_select_n, read_enable_n, write_enable_n, A0, data bus and interrupt_acknowledge_n.
- On start, writes the programmed ICW1..ICW4 initialization sequence, then the OCW1 mask.
- Afterwards services interrupt_to_cpu with a two-pulse INTA cycle, captures the vector, and issues EOI (OCW2) and mask-update (OCW1) writes on request.
- Sits between a simple CPU/testbench master and the PIC top level.

Parameters:
- STROBE_CYCLES, 2: low width, in clocks, of every wr/rd/INTA strobe; minimum 1.
- GAP_CYCLES, 1: all-deasserted idle clocks after every bus cycle; minimum 1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin initialization
- cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4  in  8 each  ICW values; captured on start
- cfg_mask  in  8  initial OCW1 mask; captured on start
- eoi_req  in  1  pulse; send non-specific EOI
- mask_wr  in  1  pulse; write mask_data as OCW1
- mask_data  in  8  new mask; captured with mask_wr
- interrupt_to_cpu  in  1  PIC INT output, asynchronous
- data_in  in  8  PIC data bus, read side
- chip_select_n, read_enable_n, write_enable_n  out  1 each  PIC strobes
- A0  out  1  PIC address
- data_out  out  8  write data
- data_oe  out  1  1 = host drives data bus
- interrupt_acknowledge_n  out  1  INTA strobe
- busy  out  1  sequencer not in IDLE/RUN_IDLE
- init_done  out  1  initialization complete
- vector  out  8  last captured vector
- vector_valid  out  1  one-cycle pulse when vector is updated

Behaviour:
- Reset values: all strobes and chip_select_n = 1; A0 = 0; data_out = 0; data_oe = 0; busy = 0; init_done = 0; vector = 0; vector_valid = 0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock.
- States: IDLE, INIT (word list), WR_SETUP, WR_STROBE, WR_HOLD, GAP, RUN_IDLE, INTA1, INTA_GAP, INTA2, INTA_FLUSH.
- Write bus cycle:
  - WR_SETUP, 1 clk: cs_n = 0, A0 and data_out valid, data_oe = 1.
  - WR_STROBE: wr_n = 0 for STROBE_CYCLES.
  - WR_HOLD, 1 clk: wr_n = 1; cs_n, A0 and data still held.
  - GAP: cs_n = 1, data_oe = 0, for GAP_CYCLES.
  - Total per write = 2 + STROBE_CYCLES + GAP_CYCLES clocks.
- Init word list:
  - ICW1 is written as cfg_icw1 | 8'h10, with A0 = 0.
  - ICW2, A0 = 1.
  - ICW3, A0 = 1, sent only if cfg_icw1[1] == 0 (cascade).
  - ICW4, A0 = 1, sent only if cfg_icw1[0] == 1 (IC4).
  - OCW1 = cfg_mask, A0 = 1.
- After the last GAP: init_done = 1, enter RUN_IDLE.
- start handling: accepted in IDLE or RUN_IDLE; clears init_done and restarts the init sequence. start while busy is ignored.
- eoi_req / mask_wr:
  - Each sets its own sticky pending flag, in any state after init.
  - They are ignored while init_done = 0.
  - A mask_wr arriving while a mask write is already pending overwrites the pending data.
- RUN_IDLE priority (highest first):
  - pending EOI: write OCW2 = 8'h20, A0 = 0;
  - pending mask: write OCW1, A0 = 1;
  - synchronized interrupt_to_cpu == 1: begin INTA.
- interrupt_to_cpu passes through a 2-flop synchronizer; latency from the pin to INTA1 is at most 3 clocks.
- INTA sequence:
  - INTA1: inta_n = 0 for STROBE_CYCLES.
  - INTA_GAP: inta_n = 1 for GAP_CYCLES.
  - INTA2: inta_n = 0 for STROBE_CYCLES; data_in is sampled on the last low clock of INTA2.
  - Next clock: vector updated, vector_valid = 1 for exactly 1 clock.
  - INTA_FLUSH: GAP_CYCLES + 2 clocks, so a stale synchronizer value cannot retrigger.
  - cs_n, rd_n, wr_n and data_oe stay deasserted throughout INTA.
- Pending EOI/mask requests raised during INTA are served after INTA_FLUSH, before any new INTA.
- busy = 1 in every state except IDLE and RUN_IDLE.

Optional Feature:
- Macro: PIC_STATUS_READ_EN.
- When defined, adds these ports:
  - status_req (in, 1)
  - status_sel (in, 1; 0 = IRR, 1 = ISR)
  - status_data (out, 8; reset 0)
  - status_valid (out, 1; reset 0)
- Behaviour with the macro:
  - A pending status request ranks below mask and above INTA.
  - It writes OCW3 = 8'h0A (IRR) or 8'h0B (ISR), A0 = 0.
  - It then runs a read cycle with A0 = 0, data_oe = 0: rd_n = 0 for STROBE_CYCLES, with cs_n low from one clock before until one clock after.
  - data_in is sampled on the last low clock; status_valid pulses for 1 clock; then GAP.
- Without the macro, the ports are absent and rd_n is held at 1 permanently.

Test Plan:
- Init, single mode: ICW1 = 0x13, ICW2 = 0x20, ICW4 = 0x01, mask = 0xFB, start.
  → Four writes: (0x13, A0=0), (0x20, 1), (0x01, 1), (0xFB, 1).
  → Each write is 5 clocks with wr_n low 2 clocks; init_done rises 20 clocks after start.
- Init, cascade without IC4: ICW1 = 0x10, ICW3 = 0x04.
  → Writes 0x10, ICW2, 0x04, mask; ICW4 is skipped; init_done is asserted.
- Interrupt: interrupt_to_cpu = 1; the bench PIC model drives 0x21 during the second INTA.
  → Exactly two INTA pulses, each 2 clocks low with a 1-clock gap.
  → vector = 0x21 and vector_valid is high for 1 clock.
  → No retrigger if the pin drops within 2 clocks after INTA2.
- Simultaneous eoi_req and mask_wr(0x7F) in RUN_IDLE with interrupt pending.
  → Order is OCW2 0x20 (A0=0), then OCW1 0x7F (A0=1), then INTA.
- reset_n asserted during WR_STROBE.
  → wr_n = 1, cs_n = 1 and data_oe = 0 asynchronously, before the next edge.
  → init_done = 0; after release the block sits in IDLE until start.
- start pulsed while busy.
  → Ignored; the sequence completes unchanged with the originally captured values.
